// File: rtl/ex_mem_stage.sv
// Y86 execute stage: ALU, condition codes and branch/cmov condition,
// followed by the EX/MEM pipeline register feeding the memory stage.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_bubble_i,
  input  logic        m_exc_i,
  input  logic        W_exc_i,
  input  logic [3:0]  ex_icode,
  input  logic [3:0]  ex_ifun,
  input  logic [31:0] ex_valA,
  input  logic [31:0] ex_valB,
  input  logic [31:0] ex_valC,
  input  logic [31:0] ex_valP,
  input  logic [3:0]  ex_dstE,
  input  logic [3:0]  ex_dstM,
  output logic [31:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [2:0]  cc_o,
  output logic [3:0]  mem_icode,
  output logic        mem_Cnd,
  output logic [31:0] mem_valE,
  output logic [31:0] mem_valA,
  output logic [31:0] mem_valP,
  output logic [3:0]  mem_dstE,
  output logic [3:0]  mem_dstM
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  logic [31:0] alu_a, alu_b, alu_e;
  logic [3:0]  alu_fun;
  logic        new_zf, new_sf, new_of;
  logic        zf, sf, of;
  logic        cnd;

  logic [2:0]  cc_d, cc_q;
  logic [3:0]  mem_icode_d, mem_icode_q;
  logic        mem_cnd_d, mem_cnd_q;
  logic [31:0] mem_val_e_d, mem_val_e_q;
  logic [31:0] mem_val_a_d, mem_val_a_q;
  logic [31:0] mem_val_p_d, mem_val_p_q;
  logic [3:0]  mem_dst_e_d, mem_dst_e_q;
  logic [3:0]  mem_dst_m_d, mem_dst_m_q;

  always_comb begin
    alu_a = 32'h0;
    case (ex_icode)
      IRRMOVL, IOPL:             alu_a = ex_valA;
      IIRMOVL, IRMMOVL, IMRMOVL: alu_a = ex_valC;
      ICALL, IPUSHL:             alu_a = 32'hFFFF_FFFC;
      IRET, IPOPL:               alu_a = 32'h0000_0004;
      default:                   alu_a = 32'h0;
    endcase

    alu_b = 32'h0;
    case (ex_icode)
      IRMMOVL, IMRMOVL, IOPL, ICALL, IPUSHL, IRET, IPOPL: alu_b = ex_valB;
      default:                                          alu_b = 32'h0;
    endcase

    alu_fun = (ex_icode == IOPL) ? ex_ifun : ALUADD;
  end

  // Undefined OPL functions yield zero and set flags the way AND would.
  always_comb begin
    alu_e  = 32'h0;
    new_of = 1'b0;
    case (alu_fun)
      ALUADD: begin
        alu_e  = alu_b + alu_a;
        new_of = (alu_a[31] == alu_b[31]) && (alu_e[31] != alu_a[31]);
      end
      ALUSUB: begin
        alu_e  = alu_b - alu_a;
        new_of = (alu_a[31] != alu_b[31]) && (alu_e[31] != alu_b[31]);
      end
      ALUAND:  alu_e = alu_b & alu_a;
      ALUXOR:  alu_e = alu_b ^ alu_a;
      default: alu_e = 32'h0;
    endcase
    new_zf = (alu_e == 32'h0);
    new_sf = alu_e[31];
  end

  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  always_comb begin
    cnd = 1'b0;
    case (ex_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of) | zf;
      4'h2:    cnd = sf ^ of;
      4'h3:    cnd = zf;
      4'h4:    cnd = ~zf;
      4'h5:    cnd = ~(sf ^ of);
      4'h6:    cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  assign e_valE = alu_e;
  assign e_Cnd  = cnd;
  assign e_dstE = ((ex_icode == IRRMOVL) && !cnd) ? RNONE : ex_dstE;

  // Flags freeze while a later stage holds an exception; the bubble does not gate them.
  always_comb begin
    cc_d = cc_q;
    if ((ex_icode == IOPL) && !m_exc_i && !W_exc_i)
      cc_d = {new_zf, new_sf, new_of};
  end

  always_comb begin
    mem_icode_d = ex_icode;
    mem_cnd_d   = cnd;
    mem_val_e_d = alu_e;
    mem_val_a_d = ex_valA;
    mem_val_p_d = ex_valP;
    mem_dst_e_d = e_dstE;
    mem_dst_m_d = ex_dstM;
    if (M_bubble_i) begin
      mem_icode_d = INOP;
      mem_cnd_d   = 1'b0;
      mem_val_e_d = mem_val_e_q;
      mem_val_a_d = mem_val_a_q;
      mem_val_p_d = mem_val_p_q;
      mem_dst_e_d = RNONE;
      mem_dst_m_d = RNONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q        <= 3'b100;
      mem_icode_q <= INOP;
      mem_cnd_q   <= 1'b0;
      mem_val_e_q <= 32'h0;
      mem_val_a_q <= 32'h0;
      mem_val_p_q <= 32'h0;
      mem_dst_e_q <= RNONE;
      mem_dst_m_q <= RNONE;
    end else begin
      cc_q        <= cc_d;
      mem_icode_q <= mem_icode_d;
      mem_cnd_q   <= mem_cnd_d;
      mem_val_e_q <= mem_val_e_d;
      mem_val_a_q <= mem_val_a_d;
      mem_val_p_q <= mem_val_p_d;
      mem_dst_e_q <= mem_dst_e_d;
      mem_dst_m_q <= mem_dst_m_d;
    end
  end

  assign cc_o      = cc_q;
  assign mem_icode = mem_icode_q;
  assign mem_Cnd   = mem_cnd_q;
  assign mem_valE  = mem_val_e_q;
  assign mem_valA  = mem_val_a_q;
  assign mem_valP  = mem_val_p_q;
  assign mem_dstE  = mem_dst_e_q;
  assign mem_dstM  = mem_dst_m_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: hand-computed ALU, flag, condition and
// pipeline-register expectations, including bubbles, exceptions and async reset.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        M_bubble_i = 1'b0;
  logic        m_exc_i = 1'b0;
  logic        W_exc_i = 1'b0;
  logic [3:0]  ex_icode = 4'h1;
  logic [3:0]  ex_ifun = 4'h0;
  logic [31:0] ex_valA = 32'h0;
  logic [31:0] ex_valB = 32'h0;
  logic [31:0] ex_valC = 32'h0;
  logic [31:0] ex_valP = 32'h0;
  logic [3:0]  ex_dstE = 4'hF;
  logic [3:0]  ex_dstM = 4'hF;
  logic [31:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  cc_o;
  logic [3:0]  mem_icode;
  logic        mem_Cnd;
  logic [31:0] mem_valE;
  logic [31:0] mem_valA;
  logic [31:0] mem_valP;
  logic [3:0]  mem_dstE;
  logic [3:0]  mem_dstM;

  int testCount = 0;
  int failCount = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .M_bubble_i(M_bubble_i), .m_exc_i(m_exc_i), .W_exc_i(W_exc_i),
    .ex_icode(ex_icode), .ex_ifun(ex_ifun), .ex_valA(ex_valA), .ex_valB(ex_valB),
    .ex_valC(ex_valC), .ex_valP(ex_valP), .ex_dstE(ex_dstE), .ex_dstM(ex_dstM),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc_o(cc_o),
    .mem_icode(mem_icode), .mem_Cnd(mem_Cnd), .mem_valE(mem_valE), .mem_valA(mem_valA),
    .mem_valP(mem_valP), .mem_dstE(mem_dstE), .mem_dstM(mem_dstM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Called just after a rising edge; inputs settle well before the next one.
  task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ifun,
                               input logic [31:0] valA, input logic [31:0] valB,
                               input logic [31:0] valC, input logic [31:0] valP,
                               input logic [3:0] dstE, input logic [3:0] dstM);
    ex_icode = icode;
    ex_ifun  = ifun;
    ex_valA  = valA;
    ex_valB  = valB;
    ex_valC  = valC;
    ex_valP  = valP;
    ex_dstE  = dstE;
    ex_dstM  = dstM;
    #1;
  endtask

  task automatic nextEdge;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_icode"}, 32'(mem_icode), 32'h1);
    checkOutput({tag, "_dstE"},  32'(mem_dstE),  32'hF);
    checkOutput({tag, "_dstM"},  32'(mem_dstM),  32'hF);
    checkOutput({tag, "_cc"},    32'(cc_o),      32'h4);
    checkOutput({tag, "_Cnd"},   32'(mem_Cnd),   32'h0);
    checkOutput({tag, "_valE"},  mem_valE,       32'h0);
    checkOutput({tag, "_valA"},  mem_valA,       32'h0);
    checkOutput({tag, "_valP"},  mem_valP,       32'h0);
  endtask

  initial begin
    // Asynchronous reset asserted between edges takes effect at once.
    nextEdge();
    #1 rst = 1'b1;
    #1;
    checkResetState("rst");
    @(negedge clk);
    rst = 1'b0;
    nextEdge();

    // ADD overflowing into the sign bit.
    applyStimulus(4'h6, 4'h0, 32'h1, 32'h7FFF_FFFF, 32'h0, 32'h10, 4'h2, 4'hF);
    checkOutput("add_e_valE", e_valE, 32'h8000_0000);
    nextEdge();
    checkOutput("add_cc",       32'(cc_o),      32'h3);
    checkOutput("add_mem_valE", mem_valE,       32'h8000_0000);
    checkOutput("add_mem_icode", 32'(mem_icode), 32'h6);
    checkOutput("add_mem_dstE", 32'(mem_dstE),  32'h2);
    checkOutput("add_mem_valA", mem_valA,       32'h1);
    checkOutput("add_mem_valP", mem_valP,       32'h10);
    checkOutput("add_mem_Cnd",  32'(mem_Cnd),   32'h1);

    // SUB to zero; e_Cnd(le) reflects the old flags ZF=0 SF=1 OF=1.
    applyStimulus(4'h6, 4'h1, 32'h5, 32'h5, 32'h0, 32'h12, 4'h3, 4'hF);
    checkOutput("sub_e_valE", e_valE, 32'h0);
    checkOutput("sub_precc_Cnd", 32'(e_Cnd), 32'h0);
    nextEdge();
    checkOutput("sub_cc", 32'(cc_o), 32'h4);

    applyStimulus(4'h7, 4'h1, 32'h0, 32'h0, 32'h40, 32'h14, 4'hF, 4'hF);
    checkOutput("jle_e_Cnd", 32'(e_Cnd), 32'h1);
    nextEdge();
    checkOutput("jle_mem_Cnd", 32'(mem_Cnd), 32'h1);

    applyStimulus(4'h7, 4'h4, 32'h0, 32'h0, 32'h40, 32'h19, 4'hF, 4'hF);
    checkOutput("jne_e_Cnd", 32'(e_Cnd), 32'h0);
    nextEdge();
    checkOutput("jne_mem_Cnd", 32'(mem_Cnd), 32'h0);

    // Conditional move squashed, then unconditional.
    applyStimulus(4'h2, 4'h4, 32'hAB, 32'h0, 32'h0, 32'h1E, 4'h3, 4'hF);
    checkOutput("cmovne_e_dstE", 32'(e_dstE), 32'hF);
    checkOutput("cmovne_e_valE", e_valE, 32'hAB);
    nextEdge();
    checkOutput("cmovne_mem_dstE", 32'(mem_dstE), 32'hF);

    applyStimulus(4'h2, 4'h0, 32'hAB, 32'h0, 32'h0, 32'h20, 4'h3, 4'hF);
    checkOutput("rrmov_e_dstE", 32'(e_dstE), 32'h3);
    nextEdge();
    checkOutput("rrmov_mem_dstE", 32'(mem_dstE), 32'h3);

    // Stack and address arithmetic; flags must not move.
    applyStimulus(4'hA, 4'h0, 32'h55, 32'h100, 32'h0, 32'h22, 4'h4, 4'hF);
    checkOutput("push_e_valE", e_valE, 32'hFC);
    nextEdge();
    applyStimulus(4'hB, 4'h0, 32'h0, 32'h100, 32'h0, 32'h24, 4'h4, 4'h1);
    checkOutput("pop_e_valE", e_valE, 32'h104);
    nextEdge();
    checkOutput("pop_mem_dstM", 32'(mem_dstM), 32'h1);
    applyStimulus(4'h5, 4'h0, 32'h0, 32'h20, 32'h8, 32'h2A, 4'hF, 4'h2);
    checkOutput("mrmov_e_valE", e_valE, 32'h28);
    nextEdge();
    applyStimulus(4'h8, 4'h0, 32'h0, 32'h200, 32'h80, 32'h2F, 4'h4, 4'hF);
    checkOutput("call_e_valE", e_valE, 32'h1FC);
    nextEdge();
    checkOutput("nonopl_cc", 32'(cc_o), 32'h4);

    // 3-5: negative, no overflow -> ZF=0 SF=1 OF=0.
    applyStimulus(4'h6, 4'h1, 32'h5, 32'h3, 32'h0, 32'h31, 4'h1, 4'hF);
    checkOutput("sub_neg_e_valE", e_valE, 32'hFFFF_FFFE);
    nextEdge();
    checkOutput("sub_neg_cc", 32'(cc_o), 32'h2);
    applyStimulus(4'h7, 4'h2, 32'h0, 32'h0, 32'h0, 32'h33, 4'hF, 4'hF);
    checkOutput("jl_e_Cnd", 32'(e_Cnd), 32'h1);
    applyStimulus(4'h7, 4'h5, 32'h0, 32'h0, 32'h0, 32'h33, 4'hF, 4'hF);
    checkOutput("jge_e_Cnd", 32'(e_Cnd), 32'h0);
    applyStimulus(4'h7, 4'h6, 32'h0, 32'h0, 32'h0, 32'h33, 4'hF, 4'hF);
    checkOutput("jg_e_Cnd", 32'(e_Cnd), 32'h0);
    applyStimulus(4'h7, 4'h3, 32'h0, 32'h0, 32'h0, 32'h33, 4'hF, 4'hF);
    checkOutput("je_e_Cnd", 32'(e_Cnd), 32'h0);
    applyStimulus(4'h7, 4'h7, 32'h0, 32'h0, 32'h0, 32'h33, 4'hF, 4'hF);
    checkOutput("j7_e_Cnd", 32'(e_Cnd), 32'h0);
    nextEdge();

    // 0x80000000-1: SUB overflow -> ZF=0 SF=0 OF=1; l and g then both taken/not.
    applyStimulus(4'h6, 4'h1, 32'h1, 32'h8000_0000, 32'h0, 32'h38, 4'h1, 4'hF);
    checkOutput("sub_ovf_e_valE", e_valE, 32'h7FFF_FFFF);
    nextEdge();
    checkOutput("sub_ovf_cc", 32'(cc_o), 32'h1);
    applyStimulus(4'h7, 4'h2, 32'h0, 32'h0, 32'h0, 32'h3A, 4'hF, 4'hF);
    checkOutput("jl_ovf_e_Cnd", 32'(e_Cnd), 32'h1);
    applyStimulus(4'h7, 4'h6, 32'h0, 32'h0, 32'h0, 32'h3A, 4'hF, 4'hF);
    checkOutput("jg_ovf_e_Cnd", 32'(e_Cnd), 32'h0);

    // AND with nonzero result sets up the bubble test; mem_valE must hold 0x30.
    applyStimulus(4'h6, 4'h2, 32'hF0, 32'h30, 32'h0, 32'h40, 4'h5, 4'hF);
    checkOutput("and_e_valE", e_valE, 32'h30);
    nextEdge();
    checkOutput("and_cc", 32'(cc_o), 32'h0);

    M_bubble_i = 1'b1;
    applyStimulus(4'h6, 4'h3, 32'h7, 32'h7, 32'h0, 32'h42, 4'h6, 4'h2);
    checkOutput("xor_e_valE", e_valE, 32'h0);
    nextEdge();
    M_bubble_i = 1'b0;
    checkOutput("bubble_icode", 32'(mem_icode), 32'h1);
    checkOutput("bubble_dstE",  32'(mem_dstE),  32'hF);
    checkOutput("bubble_dstM",  32'(mem_dstM),  32'hF);
    checkOutput("bubble_Cnd",   32'(mem_Cnd),   32'h0);
    checkOutput("bubble_valE_hold", mem_valE,   32'h30);
    checkOutput("bubble_valP_hold", mem_valP,   32'h40);
    checkOutput("bubble_cc",    32'(cc_o),      32'h4);

    // Nonzero result, then exceptions suppress only the flag write.
    applyStimulus(4'h6, 4'h0, 32'h2, 32'h3, 32'h0, 32'h44, 4'h1, 4'hF);
    nextEdge();
    checkOutput("add5_cc", 32'(cc_o), 32'h0);
    m_exc_i = 1'b1;
    applyStimulus(4'h6, 4'h3, 32'h7, 32'h7, 32'h0, 32'h46, 4'h2, 4'hF);
    nextEdge();
    m_exc_i = 1'b0;
    checkOutput("mexc_cc",    32'(cc_o),      32'h0);
    checkOutput("mexc_icode", 32'(mem_icode), 32'h6);
    checkOutput("mexc_valP",  mem_valP,       32'h46);
    W_exc_i = 1'b1;
    applyStimulus(4'h6, 4'h1, 32'h9, 32'h9, 32'h0, 32'h48, 4'h2, 4'hF);
    nextEdge();
    W_exc_i = 1'b0;
    checkOutput("wexc_cc", 32'(cc_o), 32'h0);

    // Undefined OPL function: zero result, flags as for AND.
    applyStimulus(4'h6, 4'h8, 32'h12, 32'h34, 32'h0, 32'h4A, 4'h2, 4'hF);
    checkOutput("op8_e_valE", e_valE, 32'h0);
    nextEdge();
    checkOutput("op8_cc", 32'(cc_o), 32'h4);

    // Mid-stream reset: immediate effect, then first edge latches normally.
    applyStimulus(4'h3, 4'h0, 32'h0, 32'h0, 32'h77, 32'h50, 4'h7, 4'hF);
    #1 rst = 1'b1;
    #1;
    checkResetState("rst2");
    @(negedge clk);
    rst = 1'b0;
    nextEdge();
    checkOutput("postrst_icode", 32'(mem_icode), 32'h3);
    checkOutput("postrst_valE",  mem_valE,       32'h77);
    checkOutput("postrst_dstE",  32'(mem_dstE),  32'h7);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
